cpu_sequencer: RTL and testbench



---
 rtl/cpu_sequencer_pkg.sv | 65 ++++++
 rtl/cpu_sequencer_if.sv | 34 +++
 rtl/cpu_sequencer_wait_timer.sv | 23 ++
 rtl/cpu_sequencer.sv | 119 +++++++++++
 tb/tb_cpu_sequencer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Shared opcode/ALU encodings, FSM state type and decode helpers for the
// multi-cycle accumulator CPU sequencer.
package cpu_sequencer_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_NOT   = 4'h7;
    localparam logic [3:0] OP_JMP   = 4'h8;
    localparam logic [3:0] OP_JZ    = 4'h9;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [3:0] ALU_PASSA = 4'd0;
    localparam logic [3:0] ALU_PASSB = 4'd1;
    localparam logic [3:0] ALU_ADD   = 4'd2;
    localparam logic [3:0] ALU_SUB   = 4'd3;
    localparam logic [3:0] ALU_AND   = 4'd4;
    localparam logic [3:0] ALU_OR    = 4'd5;
    localparam logic [3:0] ALU_NOT   = 4'd6;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_HALT, ST_ERROR
    } state_e;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_load;
        logic       pc_inc;
        logic       pc_load;
        logic       acc_wr;
        logic [3:0] alu_code;
    } strobe_t;

    function automatic logic op_illegal(input logic [3:0] op);
        return (op >= 4'hA) && (op <= 4'hE);
    endfunction

    // LOAD..OR are the only opcodes that touch data memory
    function automatic logic op_is_mem(input logic [3:0] op);
        return (op >= OP_LOAD) && (op <= OP_OR);
    endfunction

    function automatic logic op_writes_acc(input logic [3:0] op);
        return op_is_mem(op) && (op != OP_STORE) || (op == OP_NOT);
    endfunction

    function automatic logic [3:0] op_alu(input logic [3:0] op);
        case (op)
            OP_LOAD: return ALU_PASSB;
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_NOT:  return ALU_NOT;
            default: return ALU_PASSA;
        endcase
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control/handshake bundle between the sequencer (master) and the datapath,
// memories and debug logic (slave).
interface cpu_sequencer_if #(parameter int CNT_W = 16);
    logic             run;
    logic             step;
    logic [3:0]       op;
    logic             acc_zero;
    logic             imem_ack;
    logic             dmem_ack;
    logic             imem_req;
    logic             dmem_req;
    logic             dmem_we;
    logic             ir_load;
    logic             pc_inc;
    logic             pc_load;
    logic             acc_wr;
    logic [3:0]       alu_code;
    logic             halted;
    logic             err;
    logic             busy;
    logic [CNT_W-1:0] retired;

    modport master (
        input  run, step, op, acc_zero, imem_ack, dmem_ack,
        output imem_req, dmem_req, dmem_we, ir_load, pc_inc, pc_load, acc_wr,
               alu_code, halted, err, busy, retired
    );

    modport slave (
        output run, step, op, acc_zero, imem_ack, dmem_ack,
        input  imem_req, dmem_req, dmem_we, ir_load, pc_inc, pc_load, acc_wr,
               alu_code, halted, err, busy, retired
    );
endinterface

// File: rtl/cpu_sequencer_wait_timer.sv
// Memory-wait counter: counts ack-less request cycles and flags expiry at
// WAIT_MAX. WAIT_MAX=0 never expires.
module seq_wait_timer #(
    parameter int WAIT_MAX = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_en)  r_cnt <= r_cnt + W'(1);
    end

    assign o_expired = (WAIT_MAX != 0) && (r_cnt == W'(WAIT_MAX));
endmodule

// File: rtl/cpu_sequencer.sv
// FETCH/DECODE/EXEC control sequencer for the 12-bit accumulator CPU with
// run/step/halt control, memory-wait timeout and retired-instruction count.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 16
) (
    input logic           clk,
    input logic           rst,
    cpu_sequencer_if.master bus
);
    state_e           r_state, w_state_n;
    logic [3:0]       r_op;
    logic             r_step, r_halted, r_err;
    logic [CNT_W-1:0] r_retired;
    strobe_t          w_stb;
    logic             w_req, w_ack, w_expired, w_tout, w_done, w_tmr_clr, w_tmr_en;

    assign w_req  = (r_state == ST_FETCH) || (r_state == ST_EXEC && op_is_mem(r_op));
    assign w_ack  = (r_state == ST_FETCH) ? bus.imem_ack : bus.dmem_ack;
    assign w_tout = w_req && w_expired;
    assign w_done = (r_state == ST_EXEC) && !w_tout && (!op_is_mem(r_op) || bus.dmem_ack);

    // count restarts whenever a new request phase begins
    assign w_tmr_clr = (w_state_n == ST_FETCH || w_state_n == ST_EXEC) && (w_state_n != r_state);
    assign w_tmr_en  = w_req && !w_ack;

    seq_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_tmr_clr),
        .i_en      (w_tmr_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            ST_IDLE:   if (bus.run || bus.step) w_state_n = ST_FETCH;
            ST_FETCH:  if (w_tout) w_state_n = ST_ERROR;
                       else if (bus.imem_ack) w_state_n = ST_DECODE;
            ST_DECODE: w_state_n = op_illegal(bus.op) ? ST_ERROR : ST_EXEC;
            ST_EXEC: begin
                if (w_tout) w_state_n = ST_ERROR;
                else if (w_done) begin
                    if (r_op == OP_HALT)          w_state_n = ST_HALT;
                    else if (bus.run && !r_step)  w_state_n = ST_FETCH;
                    else                          w_state_n = ST_IDLE;
                end
            end
            default: w_state_n = r_state;
        endcase
    end

    // strobes are suppressed entirely in the cycle a timeout fires
    always_comb begin
        w_stb = '0;
        case (r_state)
            ST_FETCH: if (!w_tout) begin
                w_stb.imem_req = 1'b1;
                w_stb.ir_load  = bus.imem_ack;
            end
            ST_EXEC: if (!w_tout) begin
                w_stb.dmem_req = op_is_mem(r_op);
                w_stb.dmem_we  = (r_op == OP_STORE);
                w_stb.alu_code = op_alu(r_op);
                if (w_done) begin
                    w_stb.acc_wr = op_writes_acc(r_op);
                    case (r_op)
                        OP_JMP:  w_stb.pc_load = 1'b1;
                        OP_JZ:   begin
                            w_stb.pc_load = bus.acc_zero;
                            w_stb.pc_inc  = !bus.acc_zero;
                        end
                        OP_HALT: w_stb.pc_inc = 1'b0;
                        default: w_stb.pc_inc = 1'b1;
                    endcase
                end
            end
            default: w_stb = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op      <= '0;
            r_step    <= 1'b0;
            r_halted  <= 1'b0;
            r_err     <= 1'b0;
            r_retired <= '0;
        end else begin
            if (r_state == ST_DECODE) r_op <= bus.op;
            if (r_state == ST_IDLE && w_state_n == ST_FETCH) r_step <= !bus.run;
            else if (w_state_n == ST_IDLE)                   r_step <= 1'b0;
            if (w_done)                       r_retired <= r_retired + CNT_W'(1);
            if (w_done && r_op == OP_HALT)    r_halted  <= 1'b1;
            if (w_state_n == ST_ERROR)        r_err     <= 1'b1;
        end
    end

    assign bus.imem_req = w_stb.imem_req;
    assign bus.dmem_req = w_stb.dmem_req;
    assign bus.dmem_we  = w_stb.dmem_we;
    assign bus.ir_load  = w_stb.ir_load;
    assign bus.pc_inc   = w_stb.pc_inc;
    assign bus.pc_load  = w_stb.pc_load;
    assign bus.acc_wr   = w_stb.acc_wr;
    assign bus.alu_code = w_stb.alu_code;
    assign bus.halted   = r_halted;
    assign bus.err      = r_err;
    assign bus.busy     = (r_state == ST_FETCH) || (r_state == ST_DECODE) || (r_state == ST_EXEC);
    assign bus.retired  = r_retired;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: completion strobes checked against a
// scoreboard queue, control/boundary behaviour checked inline.
module tb_cpu_sequencer;
    import cpu_sequencer_pkg::*;

    localparam int WM = 4;
    localparam int CW = 4;

    typedef struct packed {
        logic       ireq, dreq, dwe, irl, inc, ld, accw;
        logic [3:0] alu;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errs = 0;
    int   checks = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    cpu_sequencer_if #(.CNT_W(CW)) sif ();

    cpu_sequencer #(.WAIT_MAX(WM), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.master)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t strobes();
        return exp_t'({sif.imem_req, sif.dmem_req, sif.dmem_we, sif.ir_load,
                       sif.pc_inc, sif.pc_load, sif.acc_wr, sif.alu_code});
    endfunction

    function automatic logic [13:0] outs();
        return {strobes(), sif.halted, sif.err, sif.busy};
    endfunction

    // completing-cycle strobes expected for each opcode
    function automatic exp_t exp_of(input logic [3:0] o, input logic az);
        exp_t e = '0;
        case (o)
            4'h0: e.inc = 1'b1;
            4'h1: begin e.dreq = 1'b1; e.inc = 1'b1; e.accw = 1'b1; e.alu = 4'd1; end
            4'h2: begin e.dreq = 1'b1; e.dwe = 1'b1; e.inc = 1'b1; e.alu = 4'd0; end
            4'h3, 4'h4, 4'h5, 4'h6: begin
                e.dreq = 1'b1; e.inc = 1'b1; e.accw = 1'b1; e.alu = o - 4'd1;
            end
            4'h7: begin e.inc = 1'b1; e.accw = 1'b1; e.alu = 4'd6; end
            4'h8: e.ld = 1'b1;
            4'h9: begin e.ld = az; e.inc = !az; end
            default: e = '0;
        endcase
        return e;
    endfunction

    always begin
        @(negedge clk);
        #2;
        if (rst && (sif.pc_inc || sif.pc_load)) begin
            if (sb_q.size() == 0) begin
                checks++;
                errs++;
                $error("FAIL sb_unexpected observed=%0h expected=none", strobes());
            end else begin
                chk("sb_strobes", 32'(strobes()), 32'(sb_q.pop_front()));
            end
        end
    end

    // waits for FETCH, issues one instruction and checks its latency
    task automatic do_instr(input logic [3:0] o, input logic az, input int dd);
        int n = 0;
        while (!sif.imem_req && n < 20) begin tick(1); n++; end
        chk("fetch_seen", 32'(sif.imem_req), 32'd1);
        sif.op       = o;
        sif.acc_zero = az;
        sb_q.push_back(exp_of(o, az));
        n = 0;
        if (dd > 0) begin
            sif.dmem_ack = 1'b0;
            repeat (2 + dd) begin tick(1); n++; end
            sif.dmem_ack = 1'b1;
            #1;
        end
        while (!(sif.pc_inc || sif.pc_load) && n < 20) begin tick(1); n++; end
        chk("latency", 32'(n), 32'(2 + dd));
    endtask

    task automatic do_reset();
        sif.run  = 1'b0;
        sif.step = 1'b0;
        rst      = 1'b0;
        tick(1);
        rst      = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sif.run = 1'b0; sif.step = 1'b0; sif.op = 4'h0; sif.acc_zero = 1'b0;
        sif.imem_ack = 1'b0; sif.dmem_ack = 1'b0;
        tick(2);
        rst = 1'b1;

        // reset while LOAD is stalled in EXEC
        sif.run = 1'b1; sif.op = OP_LOAD; sif.imem_ack = 1'b1;
        tick(3);
        chk("load_exec_req", 32'({sif.dmem_req, sif.alu_code, sif.acc_wr, sif.pc_inc}),
            32'({1'b1, 4'd1, 1'b0, 1'b0}));
        tick(1);
        sif.run = 1'b0; rst = 1'b0;
        #1;
        chk("rst_outs", 32'(outs()), 32'd0);
        chk("rst_retired", 32'(sif.retired), 32'd0);
        tick(1);
        chk("rst_hold_outs", 32'(outs()), 32'd0);
        rst = 1'b1;

        // free-run program LOAD, ADD, STORE, HALT
        sif.dmem_ack = 1'b1; sif.run = 1'b1;
        do_instr(OP_LOAD, 1'b0, 0);
        do_instr(OP_ADD, 1'b0, 0);
        do_instr(OP_STORE, 1'b0, 0);
        tick(1);
        chk("halt_fetch", 32'(sif.imem_req), 32'd1);
        sif.op = OP_HALT;
        tick(2);
        chk("halt_exec", 32'({strobes(), sif.busy}), 32'({11'd0, 1'b1}));
        tick(1);
        chk("halted", 32'({sif.halted, sif.busy, sif.err}), 32'd4);
        chk("prog_retired", 32'(sif.retired), 32'd4);
        repeat (3) begin
            tick(1);
            chk("halt_quiet", 32'(strobes()), 32'd0);
        end

        // branches and delayed data acks
        do_reset();
        sif.run = 1'b1;
        do_instr(OP_JZ, 1'b1, 0);
        do_instr(OP_JZ, 1'b0, 0);
        do_instr(OP_JMP, 1'b0, 0);
        do_instr(OP_LOAD, 1'b0, 2);
        do_instr(OP_SUB, 1'b0, 1);
        do_instr(OP_OR, 1'b0, 0);
        do_instr(OP_AND, 1'b0, 0);
        sif.run = 1'b0;
        tick(1);
        chk("run_drop_idle", 32'(sif.busy), 32'd0);
        chk("br_retired", 32'(sif.retired), 32'd7);

        // single step of NOT, second step while busy ignored
        do_reset();
        sif.step = 1'b1; sif.op = OP_NOT;
        tick(1);
        sif.step = 1'b0;
        do_instr(OP_NOT, 1'b0, 0);
        sif.step = 1'b1;
        tick(1);
        sif.step = 1'b0;
        chk("step_idle", 32'(sif.busy), 32'd0);
        chk("step_retired", 32'(sif.retired), 32'd1);
        tick(3);
        chk("step_stay", 32'(sif.busy), 32'd0);
        chk("step_retired2", 32'(sif.retired), 32'd1);

        // data-memory timeout on ADD
        do_reset();
        sif.op = OP_ADD; sif.dmem_ack = 1'b0; sif.run = 1'b1;
        tick(3);
        chk("to_req0", 32'({sif.dmem_req, sif.alu_code}), 32'({1'b1, 4'd2}));
        tick(3);
        chk("to_req3", 32'({sif.dmem_req, sif.err}), 32'd2);
        tick(1);
        chk("to_expire", 32'({strobes(), sif.err, sif.busy}), 32'({11'd0, 1'b0, 1'b1}));
        tick(1);
        chk("to_err", 32'({sif.err, sif.busy}), 32'd2);
        sif.dmem_ack = 1'b1;
        tick(1);
        chk("to_quiet", 32'({strobes(), sif.err}), 32'({11'd0, 1'b1}));
        chk("to_retired", 32'(sif.retired), 32'd0);
        do_reset();
        chk("to_rst_err", 32'(sif.err), 32'd0);

        // illegal opcode
        sif.op = 4'hC; sif.run = 1'b1;
        tick(2);
        chk("ill_decode", 32'({strobes(), sif.busy}), 32'({11'd0, 1'b1}));
        tick(1);
        chk("ill_err", 32'(outs()), 32'd2);
        tick(2);
        chk("ill_stay", 32'(outs()), 32'd2);
        chk("ill_retired", 32'(sif.retired), 32'd0);

        // retired counter wrap
        do_reset();
        sif.run = 1'b1;
        for (int i = 0; i < 15; i++) do_instr(OP_NOP, 1'b0, 0);
        tick(1);
        chk("wrap_pre", 32'(sif.retired), 32'd15);
        do_instr(OP_NOP, 1'b0, 0);
        sif.run = 1'b0;
        tick(1);
        chk("wrap_zero", 32'(sif.retired), 32'd0);
        chk("wrap_idle", 32'(sif.busy), 32'd0);

        tick(2);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
